store_narrow_rmw: RTL and testbench
===================================

# store_narrow_rmw

Store-side counterpart to the load-path sign/zero extenders: takes a 32-bit register value plus a byte address and store size (SB/SH/SW) from the MEM stage and narrows it into the word-addressed data memory. Word stores go straight to memory. Byte and halfword stores perform a read-modify-write: read the word, replace the addressed lane(s) with the low bits of the register value, write the word back. Sits between the MEM-stage store request and the data memory port; the pipeline stalls on `Ready` low.

## Interface
- No parameters; data width fixed at 32, memory word address 30 bits.
- `Clk` in 1: rising-edge clock.
- `Rst_n` in 1: asynchronous, active-low reset.
- `Req` in 1: store request, sampled only when `Ready`=1.
- `Size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `Addr` in 32: byte address of the store.
- `WriteData` in 32: register value; only the low 8/16/32 bits are used.
- `Ready` out 1: unit idle, can accept `Req` this cycle.
- `Done` out 1: one-cycle pulse, store committed (coincides with `MemWrite`).
- `Err` out 1: one-cycle pulse, request rejected (misaligned or illegal size).
- `MemAddr` out 30: word address, equal to `Addr[31:2]` of the accepted request.
- `MemRead` out 1: read strobe. Memory returns data on `MemReadData` in the following cycle.
- `MemReadData` in 32: memory read data.
- `MemWrite` out 1: write strobe for `MemWriteData` at `MemAddr`.
- `MemWriteData` out 32: merged word.

## Operation
- Lanes are little-endian. Byte k (k = `Addr[1:0]`) occupies bits [8k+7:8k]. A halfword with `Addr[1]`=0 occupies [15:0]; with `Addr[1]`=1 it occupies [31:16].
- On acceptance (`Req`=1, `Ready`=1) the unit registers `Addr[31:2]`, the lane offset, `Size`, and `WriteData`. Later input changes are ignored until the next acceptance.
- Error checks are done at acceptance:
  - A halfword with `Addr[0]`=1 is an error.
  - A word with `Addr[1:0]`≠0 is an error.
  - `Size`=11 is an error.
  - On any error: `Err` pulses, no memory access occurs, and the unit stays ready.
- State machine:
  - IDLE: `Ready`=1.
    - Valid word request → WRITE.
    - Valid byte/half request → READ.
    - Error → IDLE, with `Err` pulsed next cycle.
  - READ: `MemRead`=1, `MemAddr` valid → MERGE.
  - MERGE: capture `MemReadData`, overwrite the addressed lane(s) with `WriteData[7:0]` or `[15:0]`, keep the other bits unchanged → WRITE.
  - WRITE: `MemWrite`=1, `Done`=1, `MemWriteData` = merged word (word store: `WriteData` unchanged) → IDLE.
- `Req` while `Ready`=0 is ignored. It is neither queued nor flagged; the requester must hold it.
- All outputs are registered except `Ready`, which decodes the state register.

## Timing
- Reset (async assert, sync release) forces the following:
  - State IDLE, so `Ready`=1.
  - `Done`, `Err`, `MemRead`, `MemWrite` all 0.
  - `MemAddr`, `MemWriteData`, and internal captures all 0.
- Reset asserted in any state aborts the operation. No `MemWrite` or `Done` is issued for the aborted request.
- Request accepted at edge N:
  - Word store: `MemWrite`/`Done` high during cycle N+1. `Ready` returns in cycle N+2.
  - Byte/half store: `MemRead` in N+1, capture in N+2, `MemWrite`/`Done` in N+3. `Ready` returns in N+4.
  - Error: `Err` high during cycle N+1. `Ready` stays 1, so a new request may be accepted at edge N+1.
- `Done`, `Err`, `MemRead`, `MemWrite` are each exactly one cycle wide. `Done` and `Err` are never high together.
- `MemAddr` stays stable from the READ cycle through the WRITE cycle.

## Test plan
- Memory word 4 = 0x11223344. SB with `WriteData`=0xAABBCCDD at `Addr`=0x11 → `MemRead` with `MemAddr`=4 at N+1. At N+3, `MemWrite` with `MemWriteData`=0x1122DD44 and `Done`=1.
- Same initial word. SH with 0x0000BEEF at `Addr`=0x12 → `MemWriteData`=0xBEEF3344 at N+3. SB 0x5A at `Addr`=0x10 → 0x1122335A.
- SW with 0xCAFEF00D at `Addr`=0x20 → no `MemRead`. At N+1, `MemWrite` with `MemAddr`=8 and data 0xCAFEF00D. `Ready`=1 at N+2.
- Each of the following → `Err` pulse at N+1, no `MemRead`/`MemWrite`, `Ready` stays 1:
  - SH at `Addr`=0x13.
  - SW at `Addr`=0x02.
  - `Size`=11.
- Back-to-back: SB accepted at N, new `Req` held during N+1..N+3 → second request ignored until `Ready`. It is accepted at edge N+4 and its write lands at N+7.
- `Rst_n` low during MERGE of an SB → all outputs 0 immediately. No `MemWrite` after release. `Ready`=1 at the first post-reset cycle.

Source files
------------

// File: rtl/store_narrow_rmw.sv
// Store narrowing unit: word stores write straight through, byte/halfword
// stores read-modify-write the addressed word of the data memory.
module store_narrow_rmw (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Req,
  input  logic [1:0]  Size,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Ready,
  output logic        Done,
  output logic        Err,
  output logic [29:0] MemAddr,
  output logic        MemRead,
  input  logic [31:0] MemReadData,
  output logic        MemWrite,
  output logic [31:0] MemWriteData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MERGE = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [1:0]  off_q;
  logic        half_q;
  logic [15:0] wdata_q;
  logic        accept;
  logic        bad;
  logic [31:0] merged;

  assign Ready  = (state == IDLE);
  assign accept = Req & Ready;

  always_comb begin
    bad = 1'b0;
    unique case (Size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = Addr[0];
      2'b10:   bad = |Addr[1:0];
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept && !bad)
          state_d = (Size == 2'b10) ? WRITE : READ;
      end
      READ:    state_d = MERGE;
      MERGE:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Little-endian lane replacement; untouched lanes keep the memory contents.
  always_comb begin
    merged = MemReadData;
    if (half_q) begin
      if (off_q[1]) merged[31:16] = wdata_q;
      else          merged[15:0]  = wdata_q;
    end else begin
      unique case (off_q)
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        2'd3: merged[31:24] = wdata_q[7:0];
        default: merged = MemReadData;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Done         <= 1'b0;
      Err          <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddr      <= '0;
      MemWriteData <= '0;
      off_q        <= '0;
      half_q       <= 1'b0;
      wdata_q      <= '0;
    end else begin
      Done     <= (state_d == WRITE);
      MemWrite <= (state_d == WRITE);
      MemRead  <= (state_d == READ);
      Err      <= accept & bad;
      if (accept && !bad) begin
        MemAddr <= Addr[31:2];
        off_q   <= Addr[1:0];
        half_q  <= (Size == 2'b01);
        wdata_q <= WriteData[15:0];
        if (Size == 2'b10) MemWriteData <= WriteData;
      end
      if (state == MERGE) MemWriteData <= merged;
    end
  end

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Directed bench for store_narrow_rmw with a small registered-read memory model.
module tb_store_narrow_rmw;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Req;
  logic [1:0]  Size;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        Ready;
  logic        Done;
  logic        Err;
  logic [29:0] MemAddr;
  logic        MemRead;
  logic [31:0] MemReadData;
  logic        MemWrite;
  logic [31:0] MemWriteData;

  logic [31:0] mem [0:63];
  int checks = 0;
  int failures = 0;

  store_narrow_rmw dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req          (Req),
    .Size         (Size),
    .Addr         (Addr),
    .WriteData    (WriteData),
    .Ready        (Ready),
    .Done         (Done),
    .Err          (Err),
    .MemAddr      (MemAddr),
    .MemRead      (MemRead),
    .MemReadData  (MemReadData),
    .MemWrite     (MemWrite),
    .MemWriteData (MemWriteData)
  );

  always #5 Clk = ~Clk;

  // Memory returns read data in the cycle after the read strobe.
  always @(posedge Clk) begin
    if (MemRead) MemReadData <= mem[MemAddr[5:0]];
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of cycle N+4.
  task automatic do_rmw(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_addr, input logic [31:0] exp_data);
    Req = 1'b1; Size = sz; Addr = a; WriteData = wd;
    @(negedge Clk);
    chk1("rmw_n1_memread", MemRead, 1'b1);
    chk32("rmw_n1_memaddr", {2'b00, MemAddr}, exp_addr);
    chk1("rmw_n1_ready", Ready, 1'b0);
    chk1("rmw_n1_memwrite", MemWrite, 1'b0);
    Req = 1'b0; WriteData = 32'hFFFF_FFFF; Addr = 32'h0000_0003;
    @(negedge Clk);
    chk1("rmw_n2_memread", MemRead, 1'b0);
    chk1("rmw_n2_memwrite", MemWrite, 1'b0);
    chk32("rmw_n2_memaddr", {2'b00, MemAddr}, exp_addr);
    @(negedge Clk);
    chk1("rmw_n3_memwrite", MemWrite, 1'b1);
    chk1("rmw_n3_done", Done, 1'b1);
    chk32("rmw_n3_data", MemWriteData, exp_data);
    chk32("rmw_n3_memaddr", {2'b00, MemAddr}, exp_addr);
    @(negedge Clk);
    chk1("rmw_n4_ready", Ready, 1'b1);
    chk1("rmw_n4_memwrite", MemWrite, 1'b0);
    chk1("rmw_n4_done", Done, 1'b0);
  endtask

  // Returns at the negedge of cycle N+2.
  task automatic do_word(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_addr);
    Req = 1'b1; Size = 2'b10; Addr = a; WriteData = wd;
    @(negedge Clk);
    chk1("sw_n1_memwrite", MemWrite, 1'b1);
    chk1("sw_n1_done", Done, 1'b1);
    chk1("sw_n1_memread", MemRead, 1'b0);
    chk1("sw_n1_err", Err, 1'b0);
    chk32("sw_n1_memaddr", {2'b00, MemAddr}, exp_addr);
    chk32("sw_n1_data", MemWriteData, wd);
    chk1("sw_n1_ready", Ready, 1'b0);
    Req = 1'b0;
    @(negedge Clk);
    chk1("sw_n2_ready", Ready, 1'b1);
    chk1("sw_n2_memwrite", MemWrite, 1'b0);
  endtask

  // Returns at the negedge of cycle N+1 with Req dropped.
  task automatic do_err(input string tag, input logic [1:0] sz, input logic [31:0] a);
    Req = 1'b1; Size = sz; Addr = a; WriteData = 32'h1234_5678;
    @(negedge Clk);
    chk1({tag, "_err"}, Err, 1'b1);
    chk1({tag, "_ready"}, Ready, 1'b1);
    chk1({tag, "_memread"}, MemRead, 1'b0);
    chk1({tag, "_memwrite"}, MemWrite, 1'b0);
    chk1({tag, "_done"}, Done, 1'b0);
    Req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    MemReadData = '0;
    Rst_n = 1'b0; Req = 1'b0; Size = 2'b00; Addr = '0; WriteData = '0;
    repeat (2) @(negedge Clk);
    chk1("rst_ready", Ready, 1'b1);
    chk1("rst_done", Done, 1'b0);
    chk1("rst_err", Err, 1'b0);
    chk1("rst_memread", MemRead, 1'b0);
    chk1("rst_memwrite", MemWrite, 1'b0);
    chk32("rst_memaddr", {2'b00, MemAddr}, 32'h0);
    chk32("rst_memwdata", MemWriteData, 32'h0);
    Rst_n = 1'b1;
    @(negedge Clk);

    mem[4] = 32'h1122_3344;
    do_rmw(2'b00, 32'h0000_0011, 32'hAABB_CCDD, 32'd4, 32'h1122_DD44);
    do_rmw(2'b01, 32'h0000_0012, 32'h0000_BEEF, 32'd4, 32'hBEEF_3344);
    do_rmw(2'b00, 32'h0000_0010, 32'h0000_005A, 32'd4, 32'h1122_335A);
    do_rmw(2'b00, 32'h0000_0013, 32'h0000_00EE, 32'd4, 32'hEE22_3344);
    do_rmw(2'b01, 32'h0000_0010, 32'h7777_BEEF, 32'd4, 32'h1122_BEEF);
    do_rmw(2'b00, 32'h0000_0012, 32'h0000_0066, 32'd4, 32'h1166_3344);

    do_word(32'h0000_0020, 32'hCAFE_F00D, 32'd8);

    // Each error leaves the unit ready; the next request is accepted at N+1.
    do_err("sh_misaligned", 2'b01, 32'h0000_0013);
    do_err("sw_misaligned", 2'b10, 32'h0000_0002);
    do_err("size_illegal", 2'b11, 32'h0000_0010);
    do_word(32'h0000_0024, 32'h0BAD_F00D, 32'd9);

    // Back-to-back: second request held while busy, accepted at edge N+4.
    mem[4] = 32'h1122_3344;
    mem[8] = 32'h5566_7788;
    Req = 1'b1; Size = 2'b00; Addr = 32'h0000_0011; WriteData = 32'h0000_00AA;
    @(negedge Clk);
    chk1("b2b_n1_memread", MemRead, 1'b1);
    Size = 2'b01; Addr = 32'h0000_0022; WriteData = 32'h0000_1234;
    @(negedge Clk);
    chk1("b2b_n2_memread", MemRead, 1'b0);
    chk1("b2b_n2_ready", Ready, 1'b0);
    @(negedge Clk);
    chk1("b2b_n3_memwrite", MemWrite, 1'b1);
    chk32("b2b_n3_data", MemWriteData, 32'h1122_AA44);
    chk32("b2b_n3_memaddr", {2'b00, MemAddr}, 32'd4);
    @(negedge Clk);
    chk1("b2b_n4_ready", Ready, 1'b1);
    chk1("b2b_n4_memread", MemRead, 1'b0);
    @(negedge Clk);
    chk1("b2b_n5_memread", MemRead, 1'b1);
    chk32("b2b_n5_memaddr", {2'b00, MemAddr}, 32'd8);
    Req = 1'b0;
    @(negedge Clk);
    chk1("b2b_n6_memwrite", MemWrite, 1'b0);
    @(negedge Clk);
    chk1("b2b_n7_memwrite", MemWrite, 1'b1);
    chk1("b2b_n7_done", Done, 1'b1);
    chk32("b2b_n7_data", MemWriteData, 32'h1234_7788);
    @(negedge Clk);
    chk1("b2b_n8_ready", Ready, 1'b1);

    // Reset during MERGE aborts the byte store.
    mem[4] = 32'h1122_3344;
    Req = 1'b1; Size = 2'b00; Addr = 32'h0000_0011; WriteData = 32'h0000_0077;
    @(negedge Clk);
    chk1("abort_n1_memread", MemRead, 1'b1);
    Req = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk1("abort_ready", Ready, 1'b1);
    chk1("abort_done", Done, 1'b0);
    chk1("abort_memread", MemRead, 1'b0);
    chk1("abort_memwrite", MemWrite, 1'b0);
    chk32("abort_memaddr", {2'b00, MemAddr}, 32'h0);
    chk32("abort_memwdata", MemWriteData, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk1("post_rst_ready", Ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      chk1("post_rst_memwrite", MemWrite, 1'b0);
      chk1("post_rst_done", Done, 1'b0);
      @(negedge Clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
